// File: rtl/pc_seq_pkg.sv
// Shared constants for the program-counter sequencer.
// Jump-type encodings from the control decoder and the default PC width.
package pc_seq_pkg;

    localparam int PC_W_DEF = 12;

    localparam logic [2:0] JT_NONE = 3'd0;
    localparam logic [2:0] JT_JZ   = 3'd1;
    localparam logic [2:0] JT_JNZ  = 3'd2;
    localparam logic [2:0] JT_JC   = 3'd3;
    localparam logic [2:0] JT_JNC  = 3'd4;
    localparam logic [2:0] JT_JMP  = 3'd5;
    localparam logic [2:0] JT_JSB  = 3'd6;
    localparam logic [2:0] JT_RET  = 3'd7;

endpackage

// File: rtl/ret_stack.sv
// Hardware return-address LIFO; top entry is presented on dout.
// Callers must not push when full or pop when empty; such requests are ignored.
module ret_stack #(
    parameter int W     = 12,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               din,
    output logic [W-1:0]               dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [CW-1:0] r_cnt;
    logic [AW-1:0] w_top;

    assign w_top = r_cnt[AW-1:0] - AW'(1);
    assign dout  = r_mem[w_top];
    assign full  = (r_cnt == CW'(DEPTH));
    assign empty = (r_cnt == '0);
    assign count = r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (push && !full) begin
            r_cnt <= r_cnt + CW'(1);
        end else if (pop && !empty) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    // Contents need no reset; occupancy alone defines validity.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            r_mem[r_cnt[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// PC sequencer: flags, next-PC resolution and return addressing.
// RET_STACK_EN selects a full return stack; otherwise a single link register.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int              PC_W        = PC_W_DEF,
    parameter int              STACK_DEPTH = 8,
    parameter logic [PC_W-1:0] RESET_PC    = '0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           en,
    input  logic [2:0]                     jump_type,
    input  logic [PC_W-1:0]                target,
    input  logic                           flag_we,
    input  logic                           zero_in,
    input  logic                           cout_in,
    input  logic                           err_clr,
    output logic [PC_W-1:0]                pc,
    output logic                           taken,
    output logic [$clog2(STACK_DEPTH):0]   sp,
    output logic                           stk_ovf,
    output logic                           stk_unf
);
    localparam int SP_W = $clog2(STACK_DEPTH) + 1;

    logic [PC_W-1:0] r_pc;
    logic            r_taken;
    logic            r_zero;
    logic            r_cout;
    logic            r_ovf;
    logic            r_unf;

    logic [PC_W-1:0] w_inc;
    logic [PC_W-1:0] w_next;
    logic [PC_W-1:0] w_ret_addr;
    logic            w_cond;
    logic            w_jsb;
    logic            w_ret;
    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    logic            w_ovf;
    logic            w_unf;

    assign w_inc = r_pc + PC_W'(1);

    always_comb begin
        w_cond = 1'b0;
        w_jsb  = 1'b0;
        w_ret  = 1'b0;
        unique case (jump_type)
            JT_JZ:   w_cond = r_zero;
            JT_JNZ:  w_cond = !r_zero;
            JT_JC:   w_cond = r_cout;
            JT_JNC:  w_cond = !r_cout;
            JT_JMP:  w_cond = 1'b1;
            JT_JSB:  w_jsb  = 1'b1;
            JT_RET:  w_ret  = 1'b1;
            default: ;
        endcase
    end

    assign w_push = w_jsb && !w_full;
    assign w_ovf  = w_jsb && w_full;
    assign w_pop  = w_ret && !w_empty;
    assign w_unf  = w_ret && w_empty;
    assign w_next = w_pop            ? w_ret_addr :
                    (w_cond || w_jsb) ? target     : w_inc;

`ifdef RET_STACK_EN
    ret_stack #(
        .W     (PC_W),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (en && w_push),
        .pop   (en && w_pop),
        .din   (w_inc),
        .dout  (w_ret_addr),
        .count (sp),
        .full  (w_full),
        .empty (w_empty)
    );
`else
    logic [PC_W-1:0] r_link;
    logic            r_lv;

    assign w_full     = 1'b0;
    assign w_empty    = !r_lv;
    assign w_ret_addr = r_link;
    assign sp         = {{(SP_W-1){1'b0}}, r_lv};

    // A new call simply overwrites the link; nothing can overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_link <= '0;
            r_lv   <= 1'b0;
        end else if (en && w_push) begin
            r_link <= w_inc;
            r_lv   <= 1'b1;
        end else if (en && w_pop) begin
            r_lv   <= 1'b0;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc    <= RESET_PC;
            r_taken <= 1'b0;
            r_zero  <= 1'b0;
            r_cout  <= 1'b0;
        end else if (en) begin
            r_pc    <= w_next;
            r_taken <= w_cond || w_jsb || w_pop;
            if (flag_we) begin
                r_zero <= zero_in;
                r_cout <= cout_in;
            end
        end
    end

    // A fresh error in the same cycle as a clear keeps the sticky set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            r_ovf <= (en && w_ovf) || (r_ovf && !err_clr);
            r_unf <= (en && w_unf) || (r_unf && !err_clr);
        end
    end

    assign pc      = r_pc;
    assign taken   = r_taken;
    assign stk_ovf = r_ovf;
    assign stk_unf = r_unf;

endmodule
